// File: rtl/cpu_pkg.sv
/*==========================================================================
 * Module  : cpu_pkg
 * Brief   : Shared opcode, control-bit index and ALUOp encodings for the
 *           decode/execute pipeline.
 * Revision: 1.0  initial release
 *==========================================================================*/
`default_nettype none

package cpu_pkg;

    localparam int CTRL_W  = 7;
    localparam int ALUOP_W = 3;
    localparam int OP_W    = 6;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b000100;
    localparam logic [OP_W-1:0] OP_SW   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000110;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b000111;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b000001;

    // Bit positions inside the {RegDst..Branch} control vector
    localparam int CTRL_REGDST   = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 0;

    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b011;

    localparam logic [CTRL_W-1:0]  BUBBLE_CTRL = 7'b0000000;

    // Only R-type, SW and BEQ read rt as a source operand
    function automatic logic uses_rt(input logic [OP_W-1:0] opcode);
        return (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
/*==========================================================================
 * Module  : hazard_detect
 * Brief   : Combinational load-use detection between an LW in EX and the
 *           instruction currently in ID.
 * Revision: 1.0  initial release
 *==========================================================================*/
`default_nettype none

module hazard_detect
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              flush,
    output logic              load_use,
    output logic              stall
);

    logic use_rt;
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        use_rt   = uses_rt(id_opcode);
        rs_hit   = (ex_rt == id_rs);
        rt_hit   = use_rt && (ex_rt == id_rt);
        // r0 is hardwired zero, so a load into it never creates a dependency
        load_use = id_valid && ex_memread && (ex_rt != '0) && (rs_hit || rt_hit);
        stall    = load_use && !flush;
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
/*==========================================================================
 * Module  : id_ex_stage
 * Brief   : ID/EX pipeline register with load-use stall, bubble insertion
 *           on flush, and a saturating stall counter.
 * Revision: 1.0  initial release
 *==========================================================================*/
`default_nettype none

module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_opcode,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               flush,
    output logic               stall,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_wreg,
    output logic [DATA_W-1:0]  ex_rdata1,
    output logic [DATA_W-1:0]  ex_rdata2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [CNT_W-1:0]   stall_count
);

    logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
    logic [ALUOP_W-1:0] aluop_q,  aluop_d;
    logic [REG_AW-1:0]  rs_q,     rs_d;
    logic [REG_AW-1:0]  rt_q,     rt_d;
    logic [REG_AW-1:0]  wreg_q,   wreg_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [DATA_W-1:0]  rdata2_q, rdata2_d;
    logic [DATA_W-1:0]  imm_q,    imm_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic load_use;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ctrl_q[CTRL_MEMREAD]),
        .ex_rt      (rt_q),
        .flush      (flush),
        .load_use   (load_use),
        .stall      (stall)
    );

    always_comb begin
        ctrl_d   = BUBBLE_CTRL;
        aluop_d  = ALUOP_RTYPE;
        rs_d     = '0;
        rt_d     = '0;
        wreg_d   = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        cnt_d    = cnt_q;

        if (flush) begin
            // bubble; a flushed load-use is not a real stall
        end else if (load_use) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (id_valid) begin
            ctrl_d   = id_ctrl;
            aluop_d  = id_aluop;
            rs_d     = id_rs;
            rt_d     = id_rt;
            wreg_d   = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= BUBBLE_CTRL;
            aluop_q  <= ALUOP_RTYPE;
            rs_q     <= '0;
            rt_q     <= '0;
            wreg_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            aluop_q  <= aluop_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            wreg_q   <= wreg_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_ctrl     = ctrl_q;
    assign ex_aluop    = aluop_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_wreg     = wreg_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign stall_count = cnt_q;

endmodule

`default_nettype wire
